// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one registered ALU between two requesters.
// One op is in flight at a time. The result comes back to the granted port as a
// one-cycle pulse ALU_LAT+2 cycles after the handshake.
// Optional build macro: ALU_ARB_RR_EN selects round-robin arbitration.
// When it is not defined, arbitration is fixed priority with port 0 first.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready to arbitrate; reqN_ready may be high
// EXEC  | ALU inputs driven from the latched op; counting down latency
// CAPT  | alu_result valid; capture it and schedule the response pulse
module alu_arbiter #(
  parameter int DATA_W  = 8,
  parameter int OP_W    = 3,
  parameter int ALU_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              resp0_valid,
  output logic [DATA_W-1:0] resp0_data,
  output logic              resp1_valid,
  output logic [DATA_W-1:0] resp1_data,
  output logic [OP_W-1:0]   alu_control,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  output logic              busy
);

  // A one-cycle latency still needs a 1-bit counter so the terminal compare exists.
  localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    CAPT = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             id;
  logic [1:0]       grant;
  logic             hs;

`ifdef ALU_ARB_RR_EN
  logic             last_grant;

  // Round-robin arbitration: on contention, the port that did not win last time wins now.
  always_comb begin
    grant = 2'b00;
    if (req0_valid && req1_valid) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end else if (req0_valid) begin
      grant = 2'b01;
    end else if (req1_valid) begin
      grant = 2'b10;
    end
  end

  // Remember which port won the most recent handshake.
  // The reset value of 1 lets port 0 win the first contention.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (hs) begin
      last_grant <= req1_ready;
    end
  end
`else
  // Fixed-priority arbitration: port 0 wins whenever it is valid.
  always_comb begin
    grant = 2'b00;
    if (req0_valid) begin
      grant = 2'b01;
    end else if (req1_valid) begin
      grant = 2'b10;
    end
  end
`endif

  assign req0_ready = (state == IDLE) & grant[0];
  assign req1_ready = (state == IDLE) & grant[1];
  assign hs         = req0_ready | req1_ready;
  assign busy       = (state != IDLE);

  // Sequencer: latch the granted op, wait out the ALU latency, then return the result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      id          <= 1'b0;
      alu_control <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      resp0_valid <= 1'b0;
      resp1_valid <= 1'b0;
      resp0_data  <= '0;
      resp1_data  <= '0;
    end else begin
      resp0_valid <= 1'b0;
      resp1_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (hs) begin
            id          <= req1_ready;
            alu_control <= req1_ready ? req1_op : req0_op;
            alu_a       <= req1_ready ? req1_a  : req0_a;
            alu_b       <= req1_ready ? req1_b  : req0_b;
            cnt         <= CNT_W'(ALU_LAT - 1);
            state       <= EXEC;
          end
        end
        EXEC: begin
          if (cnt == '0) begin
            state <= CAPT;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        CAPT: begin
          if (id) begin
            resp1_data  <= alu_result;
            resp1_valid <= 1'b1;
          end else begin
            resp0_data  <= alu_result;
            resp0_valid <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
